// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: two-requester round-robin front end for a single
// fully associative byte cache with a registered lookup port.
// One request is in flight at a time: IDLE -> ISSUE -> CHECK -> (MISS_WAIT) -> RESP.
// Optional build macro CACHE_ARB_STATS_EN adds saturating hit/miss counters.
module cache_req_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MISS_PENALTY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [7:0]            req_wdata0,
    input  logic [7:0]            req_wdata1,
    output logic [1:0]            req_ready,
    output logic [1:0]            resp_valid,
    output logic [7:0]            resp_rdata,
    output logic                  resp_hit,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [7:0]            cache_wr_data,
    output logic                  cache_wr_en,
    input  logic                  cache_hit,
    input  logic                  cache_miss,
    input  logic [7:0]            cache_rd_data
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int CW = $clog2(MISS_PENALTY + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_CHECK     = 3'd2,
        ST_MISS_WAIT = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  wr_q, wr_d;
    logic [1:0]            resp_valid_q, resp_valid_d;
    logic [7:0]            resp_rdata_q, resp_rdata_d;
    logic                  resp_hit_q, resp_hit_d;
    logic [ADDR_WIDTH-1:0] cache_addr_q, cache_addr_d;
    logic [7:0]            cache_wr_data_q, cache_wr_data_d;
    logic                  cache_wr_en_q, cache_wr_en_d;
    logic [1:0]            grant_s;
    logic                  accept_s;
    logic                  sel_s;
    logic                  hit_s;

    // A lookup counts as a hit only when the cache flags agree.
    assign hit_s    = cache_hit & ~cache_miss;
    assign accept_s = |grant_s;
    assign sel_s    = grant_s[1];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and miss-penalty counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (hit_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_MISS_WAIT;
                    cnt_d   = CW'(MISS_PENALTY);
                end
            end
            ST_MISS_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: combinational grant plus next values of registered outputs.
    always_comb begin
        grant_s         = 2'b00;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        wr_d            = wr_q;
        resp_valid_d    = 2'b00;
        resp_rdata_d    = resp_rdata_q;
        resp_hit_d      = resp_hit_q;
        cache_addr_d    = cache_addr_q;
        cache_wr_data_d = cache_wr_data_q;
        cache_wr_en_d   = 1'b0;
        if (reset && (state_q == ST_IDLE)) begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    owner_d         = sel_s;
                    last_grant_d    = sel_s;
                    wr_d            = req_wr[sel_s];
                    cache_addr_d    = sel_s ? req_addr1 : req_addr0;
                    cache_wr_data_d = sel_s ? req_wdata1 : req_wdata0;
                    cache_wr_en_d   = req_wr[sel_s];
                end else begin
                    cache_wr_en_d   = 1'b0;
                end
            end
            ST_CHECK: begin
                resp_hit_d = hit_s;
                if (hit_s && !wr_q) begin
                    resp_rdata_d = cache_rd_data;
                end else begin
                    resp_rdata_d = 8'h00;
                end
                if (hit_s) begin
                    resp_valid_d = owner_q ? 2'b10 : 2'b01;
                end else begin
                    resp_valid_d = 2'b00;
                end
            end
            ST_MISS_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    resp_valid_d = owner_q ? 2'b10 : 2'b01;
                end else begin
                    resp_valid_d = 2'b00;
                end
            end
            default: begin
                resp_valid_d = 2'b00;
            end
        endcase
        req_ready = grant_s;
    end

    // Datapath and registered-output storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q           <= '0;
            last_grant_q    <= 1'b1;
            owner_q         <= 1'b0;
            wr_q            <= 1'b0;
            resp_valid_q    <= 2'b00;
            resp_rdata_q    <= 8'h00;
            resp_hit_q      <= 1'b0;
            cache_addr_q    <= '0;
            cache_wr_data_q <= 8'h00;
            cache_wr_en_q   <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            wr_q            <= wr_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_hit_q      <= resp_hit_d;
            cache_addr_q    <= cache_addr_d;
            cache_wr_data_q <= cache_wr_data_d;
            cache_wr_en_q   <= cache_wr_en_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_hit      = resp_hit_q;
    assign cache_addr    = cache_addr_q;
    assign cache_wr_data = cache_wr_data_q;
    assign cache_wr_en   = cache_wr_en_q;

`ifdef CACHE_ARB_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // Saturating hit/miss statistics, updated once per lookup in CHECK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else if (state_q == ST_CHECK) begin
            if (hit_s) begin
                if (hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_q <= hit_cnt_q + 16'h0001;
                end
            end else begin
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'h0001;
                end
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
